// File: rtl/data_ram.sv
// data_ram: byte-addressable data memory for the MIPS datapath.
//
// Serves LB/LBU/LH/LHU/LW/SB/SH/SW requests, one per cycle with no backpressure.
// Each accepted request produces exactly one response, in order, READ_LATENCY
// (1 or 2) cycles later. Misaligned accesses, the reserved size code and
// addresses outside the window [ADDR_BASE, ADDR_BASE+DEPTH_BYTES) are flagged
// in the response. Flagged requests never write memory and return val = 0.
//
// Parameters:
//   DEPTH_BYTES  - memory size in bytes (power of two, >= 4)
//   ADDR_BASE    - byte address of location 0 (multiple of DEPTH_BYTES)
//   READ_LATENCY - request-to-response latency in cycles (1 or 2)
//
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   req_valid    - request present this cycle
//   write_enable - 1 = store, 0 = load
//   addr         - byte address
//   size         - 00 byte, 01 half, 10 word, 11 reserved
//   sign_ext     - loads: 1 sign-extend, 0 zero-extend (ignored for words)
//   set_val      - right-justified store data
//   val          - load data (0 for stores, errors and empty slots)
//   val_valid    - response strobe
//   addr_error   - misaligned access or reserved size
//   range_error  - address outside the memory window
module data_ram #(
  parameter int unsigned DEPTH_BYTES  = 64,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        write_enable,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] set_val,
  output logic [31:0] val,
  output logic        val_valid,
  output logic        addr_error,
  output logic        range_error
);

  localparam int unsigned       WORDS    = DEPTH_BYTES / 32'd4;
  localparam int unsigned       IDX_W    = (WORDS > 32'd1) ? $clog2(WORDS) : 32'd1;
  localparam logic [31:0]       DEPTH_W  = 32'(DEPTH_BYTES);
  localparam logic [IDX_W-1:0]  IDX_MASK = IDX_W'(WORDS - 32'd1);

  // Storage: one 32-bit word per entry, lane n occupies bits [8n+7:8n].
  logic [31:0] mem_r [WORDS];

  logic [32:0]      diff_s;
  logic [31:0]      offset_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       lane_s;
  logic             align_err_s;
  logic             range_err_s;
  logic             wr_en_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;
  logic [31:0]      rd_word_s;
  logic [15:0]      rd_shift_s;
  logic [31:0]      ld_val_s;
  logic [31:0]      rsp_val_s;

  logic [31:0]      s1_val_r;
  logic             s1_valid_r;
  logic             s1_aerr_r;
  logic             s1_rerr_r;

  logic [31:0]      out_val_s;
  logic             out_valid_s;
  logic             out_aerr_s;
  logic             out_rerr_s;

  // Request decode: window offset, word index, lane and error flags.
  always_comb begin
    // The 33-bit subtraction exposes the borrow, i.e. addr < ADDR_BASE.
    diff_s      = {1'b0, addr} - {1'b0, ADDR_BASE};
    offset_s    = diff_s[31:0];
    range_err_s = diff_s[32] | (offset_s >= DEPTH_W);
    // Masking keeps the index inside the array even for out-of-window
    // addresses; those requests are flagged and never use the data.
    idx_s       = IDX_W'(offset_s >> 2) & IDX_MASK;
    lane_s      = addr[1:0];
    case (size)
      2'b00:   align_err_s = 1'b0;
      2'b01:   align_err_s = addr[0];
      2'b10:   align_err_s = (addr[1:0] != 2'b00);
      default: align_err_s = 1'b1;
    endcase
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (size)
      2'b00: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{set_val[7:0]}};
      end
      2'b01: begin
        be_s    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{set_val[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wdata_s = set_val;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
    // A request arriving in a reset cycle is discarded, so it may not write.
    wr_en_s = req_valid & write_enable & ~rst & ~align_err_s & ~range_err_s;
  end

  // Load path: read the word, right-justify the addressed lanes, extend.
  always_comb begin
    rd_word_s  = mem_r[idx_s];
    rd_shift_s = 16'(rd_word_s >> {lane_s, 3'b000});
    case (size)
      2'b00: begin
        if (sign_ext) begin
          ld_val_s = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
        end else begin
          ld_val_s = {24'h00_0000, rd_shift_s[7:0]};
        end
      end
      2'b01: begin
        if (sign_ext) begin
          ld_val_s = {{16{rd_shift_s[15]}}, rd_shift_s};
        end else begin
          ld_val_s = {16'h0000, rd_shift_s};
        end
      end
      2'b10:   ld_val_s = rd_word_s;
      default: ld_val_s = 32'h0000_0000;
    endcase
    if (req_valid & ~write_enable & ~align_err_s & ~range_err_s) begin
      rsp_val_s = ld_val_s;
    end else begin
      rsp_val_s = 32'h0000_0000;
    end
  end

  // Memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int l = 32'sd0; l < 32'sd4; l = l + 32'sd1) begin
        if (be_s[l]) begin
          mem_r[idx_s][l*32'sd8 +: 8] <= wdata_s[l*32'sd8 +: 8];
        end
      end
    end
  end

  // First response stage, loaded on the edge that ends the request cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val_r   <= 32'h0000_0000;
      s1_valid_r <= 1'b0;
      s1_aerr_r  <= 1'b0;
      s1_rerr_r  <= 1'b0;
    end else begin
      s1_val_r   <= rsp_val_s;
      s1_valid_r <= req_valid;
      s1_aerr_r  <= req_valid & align_err_s;
      s1_rerr_r  <= req_valid & range_err_s;
    end
  end

  generate
    if (READ_LATENCY == 32'd2) begin : g_lat2
      logic [31:0] s2_val_r;
      logic        s2_valid_r;
      logic        s2_aerr_r;
      logic        s2_rerr_r;

      // Second response stage carrying data, strobe and both flags.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_val_r   <= 32'h0000_0000;
          s2_valid_r <= 1'b0;
          s2_aerr_r  <= 1'b0;
          s2_rerr_r  <= 1'b0;
        end else begin
          s2_val_r   <= s1_val_r;
          s2_valid_r <= s1_valid_r;
          s2_aerr_r  <= s1_aerr_r;
          s2_rerr_r  <= s1_rerr_r;
        end
      end

      assign out_val_s   = s2_val_r;
      assign out_valid_s = s2_valid_r;
      assign out_aerr_s  = s2_aerr_r;
      assign out_rerr_s  = s2_rerr_r;
    end else begin : g_lat1
      assign out_val_s   = s1_val_r;
      assign out_valid_s = s1_valid_r;
      assign out_aerr_s  = s1_aerr_r;
      assign out_rerr_s  = s1_rerr_r;
    end
  endgenerate

  // Outputs read zero throughout a reset cycle, not only after its edge, so a
  // response due in that cycle is dropped rather than leaking out.
  always_comb begin
    if (rst) begin
      val         = 32'h0000_0000;
      val_valid   = 1'b0;
      addr_error  = 1'b0;
      range_error = 1'b0;
    end else begin
      val         = out_val_s;
      val_valid   = out_valid_s;
      addr_error  = out_aerr_s;
      range_error = out_rerr_s;
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: drives one directed request stream into two data_ram instances
// (READ_LATENCY 1 and 2) and compares every response against a per-instance
// scoreboard of expected value, flags and arrival cycle.
module tb_data_ram;

  typedef struct {
    logic [31:0] val;
    logic        ae;
    logic        re;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        write_enable;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] set_val;

  logic [31:0] val1, val2;
  logic        vv1, vv2, ae1, ae2, re1, re2;

  resp_t exp_q [2][$];
  int    cyc    = 0;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_ram #(.DEPTH_BYTES(64), .ADDR_BASE(32'h0), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .write_enable(write_enable),
    .addr(addr), .size(size), .sign_ext(sign_ext), .set_val(set_val),
    .val(val1), .val_valid(vv1), .addr_error(ae1), .range_error(re1)
  );

  data_ram #(.DEPTH_BYTES(64), .ADDR_BASE(32'h0), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .write_enable(write_enable),
    .addr(addr), .size(size), .sign_ext(sign_ext), .set_val(set_val),
    .val(val2), .val_valid(vv2), .addr_error(ae2), .range_error(re2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic vv, input logic [31:0] v,
                     input logic ae, input logic re);
    resp_t e;
    string p;
    p = (k == 0) ? "lat1" : "lat2";
    if (rst) begin
      chk({p, "_rst_valid"}, {31'b0, vv}, 32'h0);
      chk({p, "_rst_val"}, v, 32'h0);
      chk({p, "_rst_aerr"}, {31'b0, ae}, 32'h0);
      chk({p, "_rst_rerr"}, {31'b0, re}, 32'h0);
    end else if (vv) begin
      if (exp_q[k].size() == 0) begin
        chk({p, "_spurious_valid"}, {31'b0, vv}, 32'h0);
      end else begin
        e = exp_q[k].pop_front();
        chk({p, "_val"}, v, e.val);
        chk({p, "_aerr"}, {31'b0, ae}, {31'b0, e.ae});
        chk({p, "_rerr"}, {31'b0, re}, {31'b0, e.re});
        chk({p, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk({p, "_idle_val"}, v, 32'h0);
    end
  endtask

  // Response monitor, sampling away from the active edge.
  always @(negedge clk) begin
    mon(0, vv1, val1, ae1, re1);
    mon(1, vv2, val2, ae2, re2);
  end

  // One request cycle; expectations are queued when the request is driven.
  task automatic step(input logic v, input logic we, input logic [31:0] a,
                      input logic [1:0] sz, input logic sx, input logic [31:0] sv,
                      input logic [31:0] ev, input logic eae, input logic ere);
    resp_t e;
    req_valid    = v;
    write_enable = we;
    addr         = a;
    size         = sz;
    sign_ext     = sx;
    set_val      = sv;
    if (v) begin
      e.val = ev; e.ae = eae; e.re = ere;
      e.cyc = cyc + 1;
      exp_q[0].push_back(e);
      e.cyc = cyc + 2;
      exp_q[1].push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, 2'b10, 1'b0, d, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                    input logic [31:0] ev);
    step(1'b1, 1'b0, a, sz, sx, 32'h0, ev, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; write_enable = 1'b0; addr = 32'h0;
    size = 2'b00; sign_ext = 1'b0; set_val = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();

    // Word round trip and byte/half extension.
    sw(32'd4, 32'h1122_3344);
    sw(32'd8, 32'hDEAD_BEEF);
    ld(32'd8, 2'b10, 1'b0, 32'hDEAD_BEEF);
    ld(32'd8, 2'b00, 1'b1, 32'hFFFF_FFEF);
    ld(32'd11, 2'b00, 1'b0, 32'h0000_00DE);
    ld(32'd10, 2'b01, 1'b1, 32'hFFFF_DEAD);
    ld(32'd8, 2'b01, 1'b0, 32'h0000_BEEF);

    // Partial stores.
    step(1'b1, 1'b1, 32'd9, 2'b00, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    ld(32'd8, 2'b10, 1'b0, 32'hDEAD_78EF);
    step(1'b1, 1'b1, 32'd10, 2'b01, 1'b0, 32'h0000_CAFE, 32'h0, 1'b0, 1'b0);
    ld(32'd8, 2'b10, 1'b0, 32'hCAFE_78EF);
    ld(32'd8, 2'b10, 1'b1, 32'hCAFE_78EF);
    ld(32'd11, 2'b00, 1'b1, 32'hFFFF_FFCA);
    ld(32'd9, 2'b00, 1'b1, 32'h0000_0078);

    // Alignment and reserved-size errors suppress writes.
    step(1'b1, 1'b1, 32'd6, 2'b10, 1'b0, 32'hAAAA_AAAA, 32'h0, 1'b1, 1'b0);
    ld(32'd4, 2'b10, 1'b0, 32'h1122_3344);
    step(1'b1, 1'b1, 32'd4, 2'b11, 1'b0, 32'h5555_5555, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'd0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'd9, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    ld(32'd4, 2'b10, 1'b0, 32'h1122_3344);

    // Back-to-back stream.
    sw(32'd0, 32'h0000_0001);
    ld(32'd0, 2'b10, 1'b0, 32'h0000_0001);
    sw(32'd0, 32'h0000_0002);
    ld(32'd0, 2'b10, 1'b0, 32'h0000_0002);

    // Range errors; an out-of-window store must not alias onto word 0.
    step(1'b1, 1'b0, 32'd64, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'hFFFF_FFFC, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd65, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'd64, 2'b10, 1'b0, 32'h0000_0055, 32'h0, 1'b0, 1'b1);
    ld(32'd0, 2'b10, 1'b0, 32'h0000_0002);

    // req_valid low with store-like inputs: no write, no response.
    step(1'b0, 1'b1, 32'd0, 2'b10, 1'b0, 32'h7777_7777, 32'h0, 1'b0, 1'b0);
    ld(32'd0, 2'b10, 1'b0, 32'h0000_0002);
    idle();
    idle();

    // Reset with loads in flight; the store presented during reset is dropped.
    ld(32'd8, 2'b10, 1'b0, 32'hCAFE_78EF);
    ld(32'd0, 2'b10, 1'b0, 32'h0000_0002);
    exp_q[0].delete();
    exp_q[1].delete();
    rst = 1'b1;
    req_valid = 1'b1; write_enable = 1'b1; addr = 32'd0; size = 2'b10;
    set_val = 32'h0000_0099;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();
    ld(32'd8, 2'b10, 1'b0, 32'hCAFE_78EF);
    ld(32'd0, 2'b10, 1'b0, 32'h0000_0002);
    ld(32'd4, 2'b10, 1'b0, 32'h1122_3344);

    idle();
    idle();
    idle();
    chk("lat1_drain", 32'(exp_q[0].size()), 32'h0);
    chk("lat2_drain", 32'(exp_q[1].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
